dip_switch_debouncer: RTL and testbench

Upstream conditioning stage between the motherboard DIP switches and the LED controller's 4-bit switch input.
- Synchronizes each raw switch bit into the clk domain with 2 flops.
- Filters contact bounce per bit and presents a clean, stable switch vector.
- Emits a one-cycle change strobe with a per-bit mask, for downstream logic that needs edge events.
- Runs on the 48 MHz HSOSC clock used for the LED blink divider.

---
 rtl/e155_pkg.sv | 15 +
 rtl/debounce_bit.sv | 61 ++++++
 rtl/dip_switch_debouncer.sv | 45 ++++
 tb/tb_dip_switch_debouncer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/e155_pkg.sv
// Board-level constants shared by the E155 switch/LED blocks.
// Timing values are derived from the 48 MHz HSOSC.
package e155_pkg;

  localparam int HSOSC_FREQ_HZ           = 48_000_000;
  localparam int DEBOUNCE_MS             = 5;
  localparam int DEBOUNCE_CYCLES_DEFAULT = HSOSC_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int BLINK_HALF_PERIOD       = 10_000_000;

  // Width of a count that must reach cycles-1; never narrower than one bit.
  function automatic int count_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchronizer, stability counter and clean level.
// flip is combinational and marks the edge on which clean takes the new level.
module debounce_bit
  import e155_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic flip
);

  logic sync_meta;
  logic sync;
  logic mismatch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
    end
  end

  assign mismatch = sync ^ clean;

  if (DEBOUNCE_CYCLES == 1) begin : g_direct
    assign flip = mismatch;
  end else begin : g_count
    localparam int CW = count_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign flip = mismatch && (cnt == CNT_LAST);

    // Any agreement clears the run, so only unbroken mismatch reaches CNT_LAST.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (!mismatch || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clean <= 1'b0;
    end else if (flip) begin
      clean <= sync;
    end
  end

endmodule

// File: rtl/dip_switch_debouncer.sv
// Debounces the DIP switch vector and emits a registered change strobe
// with a per-bit mask, aligned to the edge on which s_clean updates.
module dip_switch_debouncer
  import e155_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_raw,
  output logic [WIDTH-1:0] s_clean,
  output logic             change_pulse,
  output logic [WIDTH-1:0] changed
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("dip_switch_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] flip;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .reset(reset),
      .raw  (s_raw[i]),
      .clean(s_clean[i]),
      .flip (flip[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      changed      <= '0;
      change_pulse <= 1'b0;
    end else begin
      changed      <= flip;
      change_pulse <= |flip;
    end
  end

endmodule

// File: tb/tb_dip_switch_debouncer.sv
// Bench for dip_switch_debouncer: directed scenarios plus random switch activity,
// compared every cycle against a sliding-window model of the debounce rule.
module tb_dip_switch_debouncer;

  localparam int W = 4;
  localparam int D = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] s_raw;
  logic [W-1:0] s_clean;
  logic         change_pulse;
  logic [W-1:0] changed;

  int vectors;
  int miscompares;
  int pulse_count;

  dip_switch_debouncer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_raw       (s_raw),
    .s_clean     (s_clean),
    .change_pulse(change_pulse),
    .changed     (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the raw sample taken at edge n is what the debouncer
  // compares at edge n+2. A bit flips when the last D compared samples all
  // disagree with the current clean level.
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_clean;
  logic [W-1:0] m_chg;
  logic         m_pulse;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hist.delete();
      for (int j = 0; j < D + 1; j++) m_hist.push_back('0);
      m_clean = '0;
      m_chg   = '0;
      m_pulse = 1'b0;
    end else begin
      logic [W-1:0] f;
      f = '0;
      for (int i = 0; i < W; i++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (m_hist[j][i] == m_clean[i]) all_diff = 1'b0;
        f[i] = all_diff;
      end
      m_clean = m_clean ^ f;
      m_chg   = f;
      m_pulse = |f;
      void'(m_hist.pop_front());
      m_hist.push_back(s_raw);
    end
  end

  always @(negedge clk) begin
    check("s_clean", s_clean, m_clean);
    check("change_pulse", 4'(change_pulse), 4'(m_pulse));
    check("changed", changed, m_chg);
    if (change_pulse) pulse_count++;
  end

  // Tasks start and end 2 time units after a rising edge.
  task automatic hold(input logic [W-1:0] v, input int n);
    s_raw = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  // s_raw was just changed; the flip must land on edge 'edges' and last one cycle.
  task automatic expect_flip(input string tag, input logic [W-1:0] exp_clean,
                             input logic [W-1:0] exp_chg, input int edges);
    repeat (edges - 1) @(posedge clk);
    #1 check({tag, "_early_pulse"}, 4'(change_pulse), 4'(0));
    @(posedge clk);
    #1;
    check({tag, "_clean"}, s_clean, exp_clean);
    check({tag, "_pulse"}, 4'(change_pulse), 4'(1));
    check({tag, "_changed"}, changed, exp_chg);
    @(posedge clk);
    #1;
    check({tag, "_pulse_drop"}, 4'(change_pulse), 4'(0));
    check({tag, "_changed_drop"}, changed, 4'b0000);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc0;
    vectors     = 0;
    miscompares = 0;
    pulse_count = 0;
    reset       = 1'b1;
    s_raw       = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Asynchronous reset with switches high, then recovery.
    hold(4'b1111, 12);
    check("pre_reset_clean", s_clean, 4'b1111);
    reset = 1'b1;
    #1;
    check("async_rst_clean", s_clean, 4'b0000);
    check("async_rst_pulse", 4'(change_pulse), 4'(0));
    check("async_rst_changed", changed, 4'b0000);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    expect_flip("rst_release", 4'b1111, 4'b1111, D + 2);

    // Clean single-bit step.
    hold(4'b0000, 12);
    s_raw = 4'b0001;
    expect_flip("clean_step", 4'b0001, 4'b0001, D + 2);

    // Bounce on bit 2 never long enough to be accepted.
    pc0 = pulse_count;
    for (int k = 0; k < 10; k++) begin
      hold(4'b0101, 3);
      hold(4'b0001, 2);
    end
    hold(4'b0001, 12);
    check("bounce_no_pulse", 4'(pulse_count), 4'(pc0));
    check("bounce_clean", s_clean, 4'b0001);

    // Bit 3 bounces, then settles high.
    for (int k = 0; k < 4; k++) begin
      hold(4'b1001, 2);
      hold(4'b0001, 2);
    end
    s_raw = 4'b1001;
    expect_flip("settle", 4'b1001, 4'b1000, D + 2);

    // Simultaneous multi-bit change, then a single-bit release.
    hold(4'b0000, 12);
    s_raw = 4'b0110;
    expect_flip("simul", 4'b0110, 4'b0110, D + 2);
    s_raw = 4'b0100;
    expect_flip("simul_release", 4'b0100, 4'b0010, D + 2);

    // Seven mismatches, one agreement, then a fresh run is required.
    hold(4'b0101, 7);
    hold(4'b0100, 1);
    s_raw = 4'b0101;
    expect_flip("near_thresh", 4'b0101, 4'b0001, D + 2);

    // Random switch activity, checked cycle by cycle by the model.
    repeat (3000) begin
      if ($urandom_range(11) == 0) s_raw = 4'($urandom);
      @(posedge clk);
      #2;
    end
    hold(s_raw, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
